control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 95 +++++++++
 rtl/control_sequencer_op_decode.sv | 47 ++++
 rtl/control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU one-hot codes,
// the sequencer state enum and the instruction classes produced by op_decode.
package control_sequencer_pkg;

  // Opcodes as found in ir[31:27]
  localparam logic [4:0] OpLd   = 5'd0;
  localparam logic [4:0] OpLdi  = 5'd1;
  localparam logic [4:0] OpSt   = 5'd2;
  localparam logic [4:0] OpAdd  = 5'd3;
  localparam logic [4:0] OpSub  = 5'd4;
  localparam logic [4:0] OpAnd  = 5'd5;
  localparam logic [4:0] OpOr   = 5'd6;
  localparam logic [4:0] OpShr  = 5'd7;
  localparam logic [4:0] OpShra = 5'd8;
  localparam logic [4:0] OpShl  = 5'd9;
  localparam logic [4:0] OpRor  = 5'd10;
  localparam logic [4:0] OpRol  = 5'd11;
  localparam logic [4:0] OpAddi = 5'd12;
  localparam logic [4:0] OpAndi = 5'd13;
  localparam logic [4:0] OpOri  = 5'd14;
  localparam logic [4:0] OpMul  = 5'd15;
  localparam logic [4:0] OpDiv  = 5'd16;
  localparam logic [4:0] OpNeg  = 5'd17;
  localparam logic [4:0] OpNot  = 5'd18;
  localparam logic [4:0] OpBr   = 5'd19;
  localparam logic [4:0] OpJr   = 5'd20;
  localparam logic [4:0] OpJal  = 5'd21;
  localparam logic [4:0] OpIn   = 5'd22;
  localparam logic [4:0] OpOut  = 5'd23;
  localparam logic [4:0] OpMfhi = 5'd24;
  localparam logic [4:0] OpMflo = 5'd25;
  localparam logic [4:0] OpNop  = 5'd26;
  localparam logic [4:0] OpHalt = 5'd27;

  // One-hot ALU operation codes; bit 11 is reserved
  localparam logic [11:0] AluNone = 12'h000;
  localparam logic [11:0] AluAdd  = 12'h001;
  localparam logic [11:0] AluSub  = 12'h002;
  localparam logic [11:0] AluAnd  = 12'h004;
  localparam logic [11:0] AluOr   = 12'h008;
  localparam logic [11:0] AluShr  = 12'h010;
  localparam logic [11:0] AluShra = 12'h020;
  localparam logic [11:0] AluShl  = 12'h040;
  localparam logic [11:0] AluRor  = 12'h080;
  localparam logic [11:0] AluRol  = 12'h100;
  localparam logic [11:0] AluNeg  = 12'h200;
  localparam logic [11:0] AluNot  = 12'h400;

  // T-steps occupy 0..7 so the low three bits are the step index
  typedef enum logic [3:0] {
    StT0     = 4'd0,
    StT1     = 4'd1,
    StT2     = 4'd2,
    StT3     = 4'd3,
    StT4     = 4'd4,
    StT5     = 4'd5,
    StT6     = 4'd6,
    StT7     = 4'd7,
    StReset  = 4'd8,
    StHalted = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,    // nop, mul, div, unassigned
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsAlu3,    // register-register ALU ops
    ClsAluImm,  // addi/andi/ori
    ClsAlu1,    // neg/not
    ClsBr,
    ClsJr,
    ClsJal,
    ClsIn,
    ClsOut,
    ClsMfhi,
    ClsMflo,
    ClsHalt
  } instr_cls_e;

  // Final T-step index of each instruction class
  function automatic logic [2:0] last_step(input instr_cls_e cls);
    logic [2:0] step;
    step = 3'd3;
    case (cls)
      ClsLd, ClsSt:               step = 3'd7;
      ClsLdi, ClsAlu3, ClsAluImm: step = 3'd5;
      ClsBr:                      step = 3'd6;
      ClsAlu1, ClsJal:            step = 3'd4;
      default:                    step = 3'd3;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/control_sequencer_op_decode.sv
// Combinational opcode decoder: ir[31:27] -> instruction class and ALU code.
module control_sequencer_op_decode
  import control_sequencer_pkg::*;
(
  input  logic [4:0]  i_opcode,
  output instr_cls_e  o_cls,
  output logic [11:0] o_alu
);

  // Classify the opcode; address arithmetic and branches use ADD
  always_comb begin
    o_cls = ClsNone;
    o_alu = AluNone;
    case (i_opcode)
      OpLd:   begin o_cls = ClsLd;     o_alu = AluAdd;  end
      OpLdi:  begin o_cls = ClsLdi;    o_alu = AluAdd;  end
      OpSt:   begin o_cls = ClsSt;     o_alu = AluAdd;  end
      OpAdd:  begin o_cls = ClsAlu3;   o_alu = AluAdd;  end
      OpSub:  begin o_cls = ClsAlu3;   o_alu = AluSub;  end
      OpAnd:  begin o_cls = ClsAlu3;   o_alu = AluAnd;  end
      OpOr:   begin o_cls = ClsAlu3;   o_alu = AluOr;   end
      OpShr:  begin o_cls = ClsAlu3;   o_alu = AluShr;  end
      OpShra: begin o_cls = ClsAlu3;   o_alu = AluShra; end
      OpShl:  begin o_cls = ClsAlu3;   o_alu = AluShl;  end
      OpRor:  begin o_cls = ClsAlu3;   o_alu = AluRor;  end
      OpRol:  begin o_cls = ClsAlu3;   o_alu = AluRol;  end
      OpAddi: begin o_cls = ClsAluImm; o_alu = AluAdd;  end
      OpAndi: begin o_cls = ClsAluImm; o_alu = AluAnd;  end
      OpOri:  begin o_cls = ClsAluImm; o_alu = AluOr;   end
      OpNeg:  begin o_cls = ClsAlu1;   o_alu = AluNeg;  end
      OpNot:  begin o_cls = ClsAlu1;   o_alu = AluNot;  end
      OpBr:   begin o_cls = ClsBr;     o_alu = AluAdd;  end
      OpJr:   o_cls = ClsJr;
      OpJal:  o_cls = ClsJal;
      OpIn:   o_cls = ClsIn;
      OpOut:  o_cls = ClsOut;
      OpMfhi: o_cls = ClsMfhi;
      OpMflo: o_cls = ClsMflo;
      OpHalt: o_cls = ClsHalt;
      default: begin
        o_cls = ClsNone;
        o_alu = AluNone;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microsequencer for the datapath: steps RESET -> T0..T7 -> HALTED and
// decodes every control strobe from (state, opcode).
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OutPortIn,
  output logic        r15write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin_in,
  output logic        Rout_in,
  output logic        BAout,
  output logic        IncPC,
  output logic        MDRRead,
  output logic        RAMread,
  output logic        RAMwrite,
  output logic        con_FF_Reset,
  output logic [11:0] ALUControl
);

  state_e     r_state;
  state_e     w_state_d;
  logic       r_halt_instr;   // HALTED was entered by the halt opcode: only clr exits
  logic       w_halt_instr_d;
  instr_cls_e w_cls;
  logic [11:0] w_alu;
  logic       w_is_last;

  // Register fields are consumed by the datapath select logic, not here
  logic w_unused_ir;
  assign w_unused_ir = ^ir[26:0];

  control_sequencer_op_decode u_op_decode (
    .i_opcode (ir[31:27]),
    .o_cls    (w_cls),
    .o_alu    (w_alu)
  );

  assign w_is_last = (r_state[2:0] == last_step(w_cls));

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= StReset;
      r_halt_instr <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_halt_instr <= w_halt_instr_d;
    end
  end

  // Next-state: fetch steps are fixed, execute steps end at the class's last step
  always_comb begin
    w_state_d      = r_state;
    w_halt_instr_d = r_halt_instr;
    unique case (r_state)
      StReset:  w_state_d = StT0;
      StT0:     w_state_d = StT1;
      StT1:     w_state_d = StT2;
      StT2:     w_state_d = StT3;
      StHalted: if (!r_halt_instr && !stop) w_state_d = StT0;
      StT3, StT4, StT5, StT6, StT7: begin
        if (w_cls == ClsHalt) begin
          w_state_d      = StHalted;
          w_halt_instr_d = 1'b1;
        end else if (w_is_last) begin
          w_state_d = stop ? StHalted : StT0;
        end else begin
          w_state_d = state_e'({1'b0, r_state[2:0] + 3'd1});
        end
      end
      default:  w_state_d = StReset;
    endcase
  end

  // Moore output decode; everything idles outside the listed steps
  always_comb begin
    run          = ~r_state[3];
    PCout        = 1'b0;
    Zhighout     = 1'b0;
    Zlowout      = 1'b0;
    MDRout       = 1'b0;
    HIout        = 1'b0;
    LOout        = 1'b0;
    Cout         = 1'b0;
    InPortout    = 1'b0;
    PCin         = 1'b0;
    MARin        = 1'b0;
    MDRin        = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Zin          = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    CONin        = 1'b0;
    OutPortIn    = 1'b0;
    r15write     = 1'b0;
    Gra          = 1'b0;
    Grb          = 1'b0;
    Grc          = 1'b0;
    Rin_in       = 1'b0;
    Rout_in      = 1'b0;
    BAout        = 1'b0;
    IncPC        = 1'b0;
    MDRRead      = 1'b0;
    RAMread      = 1'b0;
    RAMwrite     = 1'b0;
    con_FF_Reset = 1'b0;
    ALUControl   = AluNone;
    unique case (r_state)
      StT0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; con_FF_Reset = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1; PCin = 1'b1; MDRRead = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      StT3: begin
        case (w_cls)
          ClsLd, ClsLdi, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          ClsAlu3, ClsAluImm:   begin Grb = 1'b1; Rout_in = 1'b1; Yin = 1'b1; end
          ClsAlu1: begin
            Grb = 1'b1; Rout_in = 1'b1; ALUControl = w_alu; Zin = 1'b1;
          end
          ClsBr:   begin Gra = 1'b1; Rout_in = 1'b1; CONin = 1'b1; end
          ClsJr:   begin Gra = 1'b1; Rout_in = 1'b1; PCin = 1'b1; end
          ClsJal:  begin PCout = 1'b1; r15write = 1'b1; end
          ClsIn:   begin InPortout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          ClsOut:  begin Gra = 1'b1; Rout_in = 1'b1; OutPortIn = 1'b1; end
          ClsMfhi: begin HIout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          ClsMflo: begin LOout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          default: ;
        endcase
      end
      StT4: begin
        case (w_cls)
          ClsLd, ClsLdi, ClsSt, ClsAluImm: begin
            Cout = 1'b1; ALUControl = w_alu; Zin = 1'b1;
          end
          ClsAlu3: begin
            Grc = 1'b1; Rout_in = 1'b1; ALUControl = w_alu; Zin = 1'b1;
          end
          ClsAlu1: begin Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          ClsBr:   begin PCout = 1'b1; Yin = 1'b1; end
          ClsJal:  begin Gra = 1'b1; Rout_in = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        case (w_cls)
          ClsLdi, ClsAlu3, ClsAluImm: begin Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          ClsLd, ClsSt:               begin Zlowout = 1'b1; MARin = 1'b1; end
          ClsBr: begin Cout = 1'b1; ALUControl = w_alu; Zin = 1'b1; end
          default: ;
        endcase
      end
      StT6: begin
        case (w_cls)
          ClsLd:   begin MDRRead = 1'b1; RAMread = 1'b1; MDRin = 1'b1; end
          // Store data comes from the register file, not memory
          ClsSt:   begin Gra = 1'b1; Rout_in = 1'b1; MDRin = 1'b1; end
          ClsBr:   begin Zlowout = 1'b1; PCin = con_ff; end
          default: ;
        endcase
      end
      StT7: begin
        case (w_cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          ClsSt:   RAMwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer against a table-driven model of
// the per-opcode micro-steps.
module tb_control_sequencer;

  typedef logic [42:0] vec_t;

  logic        clk;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, InPortout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, r15write;
  logic        Gra, Grb, Grc, Rin_in, Rout_in, BAout;
  logic        IncPC, MDRRead, RAMread, RAMwrite, con_FF_Reset;
  logic [11:0] ALUControl;

  int total = 0;
  int bad   = 0;

  // Bit positions in the observed vector
  localparam vec_t B_PCOUT  = 43'h1 << 0;
  localparam vec_t B_ZLOW   = 43'h1 << 2;
  localparam vec_t B_MDROUT = 43'h1 << 3;
  localparam vec_t B_HIOUT  = 43'h1 << 4;
  localparam vec_t B_LOOUT  = 43'h1 << 5;
  localparam vec_t B_COUT   = 43'h1 << 6;
  localparam vec_t B_INPORT = 43'h1 << 7;
  localparam vec_t B_PCIN   = 43'h1 << 8;
  localparam vec_t B_MARIN  = 43'h1 << 9;
  localparam vec_t B_MDRIN  = 43'h1 << 10;
  localparam vec_t B_IRIN   = 43'h1 << 11;
  localparam vec_t B_YIN    = 43'h1 << 12;
  localparam vec_t B_ZIN    = 43'h1 << 13;
  localparam vec_t B_CONIN  = 43'h1 << 16;
  localparam vec_t B_OUTP   = 43'h1 << 17;
  localparam vec_t B_R15W   = 43'h1 << 18;
  localparam vec_t B_GRA    = 43'h1 << 19;
  localparam vec_t B_GRB    = 43'h1 << 20;
  localparam vec_t B_GRC    = 43'h1 << 21;
  localparam vec_t B_RIN    = 43'h1 << 22;
  localparam vec_t B_ROUT   = 43'h1 << 23;
  localparam vec_t B_BAOUT  = 43'h1 << 24;
  localparam vec_t B_INCPC  = 43'h1 << 25;
  localparam vec_t B_MDRRD  = 43'h1 << 26;
  localparam vec_t B_RAMRD  = 43'h1 << 27;
  localparam vec_t B_RAMWR  = 43'h1 << 28;
  localparam vec_t B_CONRST = 43'h1 << 29;
  localparam vec_t B_RUN    = 43'h1 << 30;
  localparam vec_t BUS_SRC  = 43'h0FF;

  vec_t obs;
  assign obs = {ALUControl, run, con_FF_Reset, RAMwrite, RAMread, MDRRead, IncPC, BAout,
                Rout_in, Rin_in, Grc, Grb, Gra, r15write, OutPortIn, CONin, LOin, HIin, Zin,
                Yin, IRin, MDRin, MARin, PCin, InPortout, Cout, LOout, HIout, MDRout, Zlowout,
                Zhighout, PCout};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn), .r15write(r15write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_in(Rin_in), .Rout_in(Rout_in), .BAout(BAout),
    .IncPC(IncPC), .MDRRead(MDRRead), .RAMread(RAMread), .RAMwrite(RAMwrite),
    .con_FF_Reset(con_FF_Reset), .ALUControl(ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t alu(input int b);
    return vec_t'(43'h1) << (31 + b);
  endfunction

  // Number of T-steps (T0 included) an opcode occupies
  function automatic int ilen(input int op);
    if (op == 0 || op == 2) return 8;
    if (op == 1 || (op >= 3 && op <= 14)) return 6;
    if (op == 17 || op == 18 || op == 21) return 5;
    if (op == 19) return 7;
    return 4;
  endfunction

  // Expected strobes for opcode op in step Ts
  function automatic vec_t model(input int op, input int s, input logic cf);
    vec_t v;
    int   ab;
    v = B_RUN;
    if (s == 0) v |= B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_CONRST;
    else if (s == 1) v |= B_ZLOW | B_PCIN | B_MDRRD | B_RAMRD | B_MDRIN;
    else if (s == 2) v |= B_MDROUT | B_IRIN;
    else if (op <= 2) begin
      if (s == 3) v |= B_GRB | B_BAOUT | B_YIN;
      else if (s == 4) v |= B_COUT | alu(0) | B_ZIN;
      else if (s == 5) v |= (op == 1) ? (B_ZLOW | B_GRA | B_RIN) : (B_ZLOW | B_MARIN);
      else if (s == 6) v |= (op == 0) ? (B_MDRRD | B_RAMRD | B_MDRIN) : (B_GRA | B_ROUT | B_MDRIN);
      else if (s == 7) v |= (op == 0) ? (B_MDROUT | B_GRA | B_RIN) : B_RAMWR;
    end else if (op <= 14) begin
      ab = (op <= 11) ? op - 3 : (op == 12) ? 0 : (op == 13) ? 2 : 3;
      if (s == 3) v |= B_GRB | B_ROUT | B_YIN;
      else if (s == 4) v |= ((op <= 11) ? (B_GRC | B_ROUT) : B_COUT) | alu(ab) | B_ZIN;
      else if (s == 5) v |= B_ZLOW | B_GRA | B_RIN;
    end else if (op == 17 || op == 18) begin
      if (s == 3) v |= B_GRB | B_ROUT | alu(op - 8) | B_ZIN;
      else if (s == 4) v |= B_ZLOW | B_GRA | B_RIN;
    end else if (op == 19) begin
      if (s == 3) v |= B_GRA | B_ROUT | B_CONIN;
      else if (s == 4) v |= B_PCOUT | B_YIN;
      else if (s == 5) v |= B_COUT | alu(0) | B_ZIN;
      else if (s == 6) v |= B_ZLOW | (cf ? B_PCIN : vec_t'(0));
    end else if (op == 20) begin
      if (s == 3) v |= B_GRA | B_ROUT | B_PCIN;
    end else if (op == 21) begin
      if (s == 3) v |= B_PCOUT | B_R15W;
      else if (s == 4) v |= B_GRA | B_ROUT | B_PCIN;
    end else if (s == 3) begin
      if (op == 22) v |= B_INPORT | B_GRA | B_RIN;
      else if (op == 23) v |= B_GRA | B_ROUT | B_OUTP;
      else if (op == 24) v |= B_HIOUT | B_GRA | B_RIN;
      else if (op == 25) v |= B_LOOUT | B_GRA | B_RIN;
    end
    return v;
  endfunction

  vec_t trace [0:15];

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  // Records n consecutive cycles starting at the current one
  task automatic capture(input int n);
    for (int s = 0; s < n; s++) begin
      trace[s] = obs;
      if (s < n - 1) next_cycle();
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
    #1 clr = 1'b0;
    #2;
    total++;
    if (obs !== vec_t'(0)) begin bad++; $display("FAIL reset_async got %h want 0", obs); end
    next_cycle();
    total++;
    if (obs !== vec_t'(0)) begin bad++; $display("FAIL reset_held got %h want 0", obs); end
    #1 clr = 1'b1;
    next_cycle();
    total++;
    if (obs !== model(0, 0, 0)) begin
      bad++; $display("FAIL reset_to_t0 got %h want %h", obs, model(0, 0, 0));
    end
  endtask

  task automatic test_ldi;
    ir = 32'h09000055;
    capture(6);
    for (int s = 0; s < 6; s++) begin
      total++;
      if (trace[s] !== model(1, s, 0)) begin
        bad++; $display("FAIL ldi_T%0d got %h want %h", s, trace[s], model(1, s, 0));
      end
    end
    next_cycle();
    total++;
    if (obs !== model(1, 0, 0)) begin
      bad++; $display("FAIL ldi_next_t0 got %h want %h", obs, model(1, 0, 0));
    end
  endtask

  task automatic test_jal;
    ir = 32'hAB000000;
    capture(5);
    for (int s = 0; s < 5; s++) begin
      total++;
      if (trace[s] !== model(21, s, 0)) begin
        bad++; $display("FAIL jal_T%0d got %h want %h", s, trace[s], model(21, s, 0));
      end
    end
    next_cycle();
    total++;
    if (obs !== model(21, 0, 0)) begin
      bad++; $display("FAIL jal_next_t0 got %h want %h", obs, model(21, 0, 0));
    end
  endtask

  task automatic test_br;
    for (int c = 0; c < 2; c++) begin
      ir = {5'd19, 27'h0123456};
      con_ff = c[0];
      capture(7);
      for (int s = 0; s < 7; s++) begin
        total++;
        if (trace[s] !== model(19, s, c[0])) begin
          bad++; $display("FAIL br%0d_T%0d got %h want %h", c, s, trace[s], model(19, s, c[0]));
        end
      end
      total++;
      if (trace[6][8] !== c[0]) begin
        bad++; $display("FAIL br%0d_pcin got %b want %b", c, trace[6][8], c[0]);
      end
      total++;
      if (trace[0][29] !== 1'b1) begin
        bad++; $display("FAIL br%0d_conrst got %b want 1", c, trace[0][29]);
      end
      next_cycle();
    end
    con_ff = 1'b0;
  endtask

  task automatic test_st;
    ir = {5'd2, 27'h1A5A5A5};
    capture(8);
    for (int s = 0; s < 8; s++) begin
      total++;
      if (trace[s] !== model(2, s, 0)) begin
        bad++; $display("FAIL st_T%0d got %h want %h", s, trace[s], model(2, s, 0));
      end
      total++;
      if (trace[s][28] !== (s == 7)) begin
        bad++; $display("FAIL st_ramwrite_T%0d got %b want %b", s, trace[s][28], s == 7);
      end
    end
    total++;
    if (trace[6][26] !== 1'b0) begin
      bad++; $display("FAIL st_mdrread_T6 got %b want 0", trace[6][26]);
    end
    next_cycle();
    total++;
    if (obs !== model(2, 0, 0)) begin
      bad++; $display("FAIL st_next_t0 got %h want %h", obs, model(2, 0, 0));
    end
  endtask

  task automatic test_clr_mid;
    ir = {5'd4, 27'h0ABCDEF};
    capture(5);
    for (int s = 0; s < 5; s++) begin
      total++;
      if (trace[s] !== model(4, s, 0)) begin
        bad++; $display("FAIL sub_T%0d got %h want %h", s, trace[s], model(4, s, 0));
      end
    end
    #1 clr = 1'b0;
    #1;
    total++;
    if (obs !== vec_t'(0)) begin bad++; $display("FAIL clr_mid_async got %h want 0", obs); end
    next_cycle();
    total++;
    if (obs !== vec_t'(0)) begin bad++; $display("FAIL clr_mid_held got %h want 0", obs); end
    #3 clr = 1'b1;
    next_cycle();
    total++;
    if (obs !== model(4, 0, 0)) begin
      bad++; $display("FAIL clr_release_t0 got %h want %h", obs, model(4, 0, 0));
    end
  endtask

  task automatic test_stop;
    ir = 32'h09000055;
    capture(5);
    next_cycle();
    stop = 1'b1;
    total++;
    if (obs !== model(1, 5, 0)) begin
      bad++; $display("FAIL stop_ldi_T5 got %h want %h", obs, model(1, 5, 0));
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      total++;
      if (obs !== vec_t'(0)) begin bad++; $display("FAIL stop_halted%0d got %h want 0", k, obs); end
    end
    stop = 1'b0;
    next_cycle();
    total++;
    if (obs !== model(1, 0, 0)) begin
      bad++; $display("FAIL stop_resume got %h want %h", obs, model(1, 0, 0));
    end
  endtask

  task automatic test_random;
    int          op;
    int          n;
    logic        sreq;
    logic [31:0] r;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 31);
      if (op == 27) op = 26;
      r = $urandom();
      ir = {op[4:0], r[26:0]};
      con_ff = 1'($urandom_range(0, 1));
      sreq = ($urandom_range(0, 5) == 0);
      stop = sreq;  // only honoured at the instruction boundary
      n = ilen(op);
      capture(n);
      for (int s = 0; s < n; s++) begin
        total++;
        if (trace[s] !== model(op, s, con_ff)) begin
          bad++; $display("FAIL rand op%0d_T%0d got %h want %h", op, s, trace[s],
                          model(op, s, con_ff));
        end
        total++;
        if ($countones(trace[s] & BUS_SRC) > 1) begin
          bad++; $display("FAIL bus_excl op%0d_T%0d got %h want <=1 source", op, s, trace[s]);
        end
      end
      next_cycle();
      if (sreq) begin
        total++;
        if (obs !== vec_t'(0)) begin bad++; $display("FAIL rand_stop op%0d got %h want 0", op, obs); end
        stop = 1'b0;
        next_cycle();
      end
      total++;
      if (obs !== model(op, 0, 0)) begin
        bad++; $display("FAIL rand_next_t0 op%0d got %h want %h", op, obs, model(op, 0, 0));
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_halt;
    ir = 32'hD8000000;
    capture(4);
    for (int s = 0; s < 4; s++) begin
      total++;
      if (trace[s] !== model(27, s, 0)) begin
        bad++; $display("FAIL halt_T%0d got %h want %h", s, trace[s], model(27, s, 0));
      end
    end
    for (int k = 0; k < 22; k++) begin
      next_cycle();
      stop = k[0];  // stop activity must not release an instruction halt
      total++;
      if (obs !== vec_t'(0)) begin bad++; $display("FAIL halt_hold%0d got %h want 0", k, obs); end
    end
    stop = 1'b0;
    #1 clr = 1'b0;
    #2 clr = 1'b1;
    next_cycle();
    total++;
    if (obs !== model(0, 0, 0)) begin
      bad++; $display("FAIL halt_clr_t0 got %h want %h", obs, model(0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_jal();
    test_br();
    test_st();
    test_clr_mid();
    test_stop();
    test_random();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
